// File: rtl/fetch_controller_pkg.sv
// Shared fetch-pipeline definitions: FSM state encoding, datapath widths
// and the NOP word used as the reset value of the instruction register.
package fetch_controller_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // FETCH: request outstanding to imem. PRESENT: instruction held for ID.
  typedef enum logic {
    FETCH   = 1'b0,
    PRESENT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst (async active-high), en (count one), clr (sync clear),
//        q (count, sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (en && q != '1)   q <= q + 1'b1;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer. Owns the PC, issues req/ready fetches to a
// variable-latency instruction memory and holds the fetched word for ID
// until consumed. A branch seen while a fetch is outstanding is remembered
// (squash) so the returning wrong-path data is dropped.
// Ports:
//   clk, rst                 clock, async active-high reset
//   freeze                   ID not accepting this cycle
//   branchTaken, branchAddr  redirect from EX
//   mem_req, mem_addr        fetch request to imem
//   mem_ready, mem_rdata     imem response
//   if_valid, instruction, pc  registered output to ID (pc = addr + PC_STEP)
//   stall_cnt                saturating count of frozen PRESENT cycles
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchAddr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pcreg_q, pcreg_d;
  logic               sq_q, sq_d;
  logic [ADDR_W-1:0]  sqt_q, sqt_d;
  logic               vld_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  pc_d;
  logic               stall_en;

  assign mem_req  = (state_q == FETCH);
  assign mem_addr = pcreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pcreg_q     <= RESET_PC;
      sq_q        <= 1'b0;
      sqt_q       <= '0;
      if_valid    <= 1'b0;
      instruction <= NOP;
      pc          <= '0;
    end else begin
      state_q     <= state_d;
      pcreg_q     <= pcreg_d;
      sq_q        <= sq_d;
      sqt_q       <= sqt_d;
      if_valid    <= vld_d;
      instruction <= instr_d;
      pc          <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcreg_d  = pcreg_q;
    sq_d     = sq_q;
    sqt_d    = sqt_q;
    vld_d    = if_valid;
    instr_d  = instruction;
    pc_d     = pc;
    stall_en = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          if (!sq_q && !branchTaken) begin
            instr_d = mem_rdata;
            pc_d    = pcreg_q + STEP;
            vld_d   = 1'b1;
            state_d = PRESENT;
          end else begin
            // Wrong-path return: drop it and re-request at the redirect;
            // a same-cycle branch is newer than any pending target.
            pcreg_d = branchTaken ? branchAddr : sqt_q;
            sq_d    = 1'b0;
          end
        end else if (branchTaken) begin
          sq_d  = 1'b1;
          sqt_d = branchAddr;
        end
      end
      PRESENT: begin
        if (branchTaken) begin
          vld_d   = 1'b0;
          pcreg_d = branchAddr;
          state_d = FETCH;
        end else if (!freeze) begin
          vld_d   = 1'b0;
          pcreg_d = pcreg_q + STEP;
          state_d = FETCH;
        end else begin
          stall_en = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .clr (1'b0),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (default params; wrap-around
// RESET_PC with a 4-bit stall counter) driven by shared stimulus, each
// compared every cycle against a behavioural model, plus directed checks.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst, freeze, bt, ready;
  logic [31:0] ba;

  logic        req_a, req_b, v_a, v_b;
  logic [31:0] addr_a, addr_b, rdata_a, rdata_b, instr_a, instr_b, pc_a, pc_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rdata_a = memf(addr_a);
  assign rdata_b = memf(addr_b);

  fetch_controller dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(bt), .branchAddr(ba),
    .mem_req(req_a), .mem_addr(addr_a), .mem_ready(ready), .mem_rdata(rdata_a),
    .if_valid(v_a), .instruction(instr_a), .pc(pc_a), .stall_cnt(cnt_a)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(bt), .branchAddr(ba),
    .mem_req(req_b), .mem_addr(addr_b), .mem_ready(ready), .mem_rdata(rdata_b),
    .if_valid(v_b), .instruction(instr_b), .pc(pc_b), .stall_cnt(cnt_b)
  );

  logic [1:0]       o_req, o_vld;
  logic [1:0][31:0] o_addr, o_instr, o_pc, o_cnt;
  assign o_req   = {req_b, req_a};
  assign o_vld   = {v_b, v_a};
  assign o_addr  = {addr_b, addr_a};
  assign o_instr = {instr_b, instr_a};
  assign o_pc    = {pc_b, pc_a};
  assign o_cnt   = {{28'b0, cnt_b}, {16'b0, cnt_a}};

  // Reference model: "holding" = an instruction is parked for ID, otherwise
  // a fetch is outstanding at fpc; redir/redir_tgt remember a branch that
  // arrived while the fetch was still in flight.
  logic [31:0] rst_pc [2] = '{32'h0, 32'hFFFF_FFFC};
  logic [31:0] cnt_max[2] = '{32'd65535, 32'd15};
  bit          holding[2], redir[2];
  logic [31:0] fpc[2], redir_tgt[2], m_instr[2], m_pc[2], m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      holding[i] = 0; redir[i] = 0; redir_tgt[i] = 0;
      fpc[i] = rst_pc[i]; m_instr[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (holding[i]) begin
        if (bt)           begin holding[i] = 0; fpc[i] = ba; end
        else if (!freeze) begin holding[i] = 0; fpc[i] = fpc[i] + 32'd4; end
        else if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end else if (ready) begin
        if (redir[i] || bt) begin
          fpc[i] = bt ? ba : redir_tgt[i];
          redir[i] = 0;
        end else begin
          m_instr[i] = memf(fpc[i]);
          m_pc[i]    = fpc[i] + 32'd4;
          holding[i] = 1;
        end
      end else if (bt) begin
        redir[i] = 1; redir_tgt[i] = ba;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req%0d", i), {31'b0, o_req[i]}, {31'b0, !holding[i]});
      if (!holding[i]) chk($sformatf("addr%0d", i), o_addr[i], fpc[i]);
      chk($sformatf("vld%0d", i), {31'b0, o_vld[i]}, {31'b0, holding[i]});
      chk($sformatf("instr%0d", i), o_instr[i], m_instr[i]);
      chk($sformatf("pc%0d", i), o_pc[i], m_pc[i]);
      chk($sformatf("cnt%0d", i), o_cnt[i], m_cnt[i]);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1ns later.
  task automatic step();
    if (rst) model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic idle();
    freeze = 0; bt = 0; ba = 0; ready = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vld"},   {31'b0, v_a}, 32'd0);
    chk({tag, "_instr"}, instr_a, 32'd0);
    chk({tag, "_pc"},    pc_a, 32'd0);
    chk({tag, "_cnt"},   {16'b0, cnt_a}, 32'd0);
    chk({tag, "_req"},   {31'b0, req_a}, 32'd1);
    chk({tag, "_addr"},  addr_a, 32'd0);
    chk({tag, "_addr_b"}, addr_b, 32'hFFFF_FFFC);
  endtask

  initial begin
    rst = 1; idle(); model_reset();
    #2;
    chk_reset_outputs("rst0");
    step(); step();
    rst = 0;

    // zero-wait memory, no freeze: fetch/present alternate
    ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("zw_addr", addr_a, 32'(4 * k));
      step();
      chk("zw_vld", {31'b0, v_a}, 32'd1);
      chk("zw_pc", pc_a, 32'(4 * k + 4));
      if (k == 0) chk("wrap_pc", pc_b, 32'd0);
      step();
      chk("zw_vld0", {31'b0, v_a}, 32'd0);
      if (k == 0) chk("wrap_addr", addr_b, 32'd0);
    end

    // 3-cycle latency at 0x10, then freeze 5 cycles
    ready = 0; step(); step();
    ready = 1; step();
    ready = 0; freeze = 1;
    for (int k = 0; k < 5; k++) begin
      chk("frz_pc", pc_a, 32'h14);
      chk("frz_instr", instr_a, memf(32'h10));
      step();
    end
    chk("frz_cnt", {16'b0, cnt_a}, 32'd5);
    chk("frz_vld", {31'b0, v_a}, 32'd1);
    freeze = 0; step();
    chk("frz_next", addr_a, 32'h14);

    // advance to 0x20, then branch one cycle into a 3-cycle fetch
    ready = 1;
    repeat (3) begin step(); step(); end
    chk("br_start", addr_a, 32'h20);
    ready = 0; step();
    bt = 1; ba = 32'h100; step();
    bt = 0; ready = 1; step();
    chk("br_drop", {31'b0, v_a}, 32'd0);
    chk("br_addr", addr_a, 32'h100);
    step();
    chk("br_pc", pc_a, 32'h104);

    // branch to 0x30 from PRESENT, then branch coincident with ready
    bt = 1; ba = 32'h30; step();
    chk("b30_addr", addr_a, 32'h30);
    ba = 32'h200; step();
    chk("coin_vld", {31'b0, v_a}, 32'd0);
    chk("coin_addr", addr_a, 32'h200);
    bt = 0; step();
    chk("coin_pc", pc_a, 32'h204);

    // branch beats freeze in PRESENT
    freeze = 1; bt = 1; ba = 32'h40; step();
    chk("bf_vld", {31'b0, v_a}, 32'd0);
    chk("bf_addr", addr_a, 32'h40);
    freeze = 0; bt = 0;
    step(); step(); step();
    bt = 1; ba = 32'h50; step();
    bt = 0; ready = 0; step();
    chk("r50_addr", addr_a, 32'h50);

    // asynchronous reset mid-fetch
    rst = 1; #1; model_reset();
    chk_reset_outputs("arst");
    step();
    rst = 0;
    chk("arst_rel", addr_a, 32'h0);

    // saturation of the 4-bit counter
    ready = 1; step();
    freeze = 1;
    repeat (20) step();
    chk("sat_b", {28'b0, cnt_b}, 32'd15);
    chk("sat_a", {16'b0, cnt_a}, 32'd20);
    idle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      freeze = ($urandom_range(0, 99) < 40);
      bt     = ($urandom_range(0, 99) < 10);
      ba     = $urandom & 32'hFFFF_FFFC;
      ready  = ($urandom_range(0, 99) < 50);
      step();
    end
    rst = 0; idle(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
